xor_pipe_unit: RTL and testbench
================================

Name: xor_pipe_unit

Overview:
- Parametrised, pipelined successor to the single-gate XOR delay model.
- Bitwise XOR/XNOR of two WIDTH-bit operands, with a running XOR accumulator.
- Gate delay is modelled as a configurable number of clock cycles of latency, not as continuous `#` delay.
- Valid/ready on both sides with full backpressure; intended as a reusable datapath leaf for parity and checksum paths.

Parameters:
- WIDTH, 8, operand/result width in bits, 1..64.
- STAGES, 2, pipeline depth (latency in cycles), 1..8.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- MODE  input  2  00 XOR, 01 XNOR, 10 ACC, 11 CLR
- IN_VALID  input  1  operand/mode valid
- IN_READY  output  1  unit can accept this cycle
- X  output  WIDTH  result
- PARITY  output  1  reduction XOR of X
- OUT_VALID  output  1  X/PARITY valid
- OUT_READY  input  1  downstream accepts

Behaviour:
- Reset
  - RST_N low clears all stage valid bits, stage data, the accumulator ACC, X, PARITY and OUT_VALID to 0, immediately and asynchronously.
  - Reset mid-operation discards all in-flight entries; no partial output appears after release.
  - IN_READY is 1 after reset (the pipe is empty).
- Handshake
  - Input transfer occurs when IN_VALID and IN_READY are both 1.
  - Output transfer occurs when OUT_VALID and OUT_READY are both 1.
  - IN_READY = !(OUT_VALID && !OUT_READY), combinational.
  - Stall is global: while the output is held, every stage holds its contents.
  - While stalled, X, PARITY and OUT_VALID remain stable.
- Pipeline
  - Stage 1 captures R = A ^ B plus MODE on input transfer.
  - Stages 2..STAGES shift when not stalled; bubbles (valid=0) propagate.
  - Stages 1..STAGES-1 compact bubbles only via the normal shift; there is no bubble collapsing.
  - Latency: input transfer at edge t produces OUT_VALID at edge t+STAGES when no stall occurs.
  - Throughput is 1 per cycle.
  - STAGES=1: the output register is stage 1.
- Output stage (the entry entering the last register)
  - XOR: X = R.
  - XNOR: X = ~R.
  - ACC: ACC <= ACC ^ R; X = ACC ^ R (the new value).
  - CLR: ACC <= 0; X = 0.
  - ACC and CLR update exactly once per entry, at the moment the entry is loaded into the output register. A stall does not re-apply the update.
  - PARITY = ^X, registered alongside X.
  - A bubble arriving at the output stage leaves ACC unchanged and clears OUT_VALID when the current output transfers or is already invalid.
- Simultaneous events
  - Output transfer and a new entry reaching the output stage in the same cycle: the new entry loads; no gap.
  - Consecutive ACC entries chain correctly at full throughput (ACC forwarding at the output stage).
- Widths: all operations are bitwise at WIDTH; there is no carry, overflow or truncation.

Optional Feature:
- Macro XOR_PIPE_STATS_EN.
- When defined:
  - Adds output port XFER_CNT (16 bits): counts output transfers; wraps 0xFFFF -> 0x0000.
  - Adds output port STALL_CNT (16 bits): counts cycles with OUT_VALID && !OUT_READY; saturates at 0xFFFF.
  - Both ports reset to 0 on RST_N.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset/latency: WIDTH=8, STAGES=2, OUT_READY=1; send A=8'hA5, B=8'h0F, MODE=00 at edge 0 -> OUT_VALID at edge 2 with X=8'hAA, PARITY=0; all outputs 0 during reset.
- XNOR and truth table: stream the four 1-bit-pattern combos A/B ∈ {00,FF}, {FF,00}, {FF,FF}, {00,00} in MODE=01 back-to-back -> X = 00, 00, FF, FF on consecutive cycles, with no bubbles.
- Accumulator: back-to-back inputs in this order:
  - CLR;
  - ACC with A=8'h01, B=0;
  - ACC with A=8'h02, B=0;
  - ACC with A=8'h03, B=0.
  - Required X sequence: 00, 01, 03, 00; PARITY sequence 0, 1, 0, 0.
- Backpressure: hold OUT_READY=0 for 5 cycles with 3 entries in flight -> IN_READY=0, X stable, ACC updated once per entry; on release, entries emerge in order, one per cycle.
- Reset mid-stream: assert RST_N=0 asynchronously (not on a clock edge) with 2 entries in flight -> OUT_VALID=0 immediately; after release with no inputs, OUT_VALID stays 0 for STAGES+2 cycles.
- Stats (XOR_PIPE_STATS_EN defined): 4 transfers with 3 stall cycles -> XFER_CNT=4, STALL_CNT=3; preload 65535 transfers -> next transfer wraps XFER_CNT to 0.

Source files
------------

// File: rtl/xor_pipe_unit.sv
// xor_pipe_unit: pipelined bitwise XOR / XNOR unit with a running XOR
// accumulator and valid/ready handshaking on both sides.
//
// Gate delay is modelled as STAGES register stages of latency. Stages
// 1..STAGES-1 carry the raw R = A ^ B plus its mode; the last stage is the
// output register, where the mode is applied and the accumulator updated.
// A single global stall (output valid but not accepted) freezes every stage.
//
// Optional build macro: XOR_PIPE_STATS_EN adds the XFER_CNT (wrapping output
// transfer count) and STALL_CNT (saturating stalled-cycle count) ports.
module xor_pipe_unit #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       MODE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] X,
    output logic             PARITY,
    output logic             OUT_VALID,
    input  logic             OUT_READY
`ifdef XOR_PIPE_STATS_EN
    ,
    output logic [15:0]      XFER_CNT,
    output logic [15:0]      STALL_CNT
`endif
);

    typedef enum logic [1:0] {
        MODE_XOR  = 2'b00,
        MODE_XNOR = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_CLR  = 2'b11
    } mode_t;

    logic             stall;
    logic             in_xfer;

    logic [WIDTH-1:0] x_q, x_d;
    logic             parity_q, parity_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    // Entry presented to the output register this cycle.
    logic             feed_vld;
    logic [WIDTH-1:0] feed_r;
    mode_t            feed_mode;

    // Global stall: the held output blocks every stage and the input.
    assign stall    = out_valid_q && !OUT_READY;
    assign IN_READY = !stall;
    assign in_xfer  = IN_VALID && IN_READY;

    generate
        if (STAGES == 1) begin : g_direct
            // With a single stage the output register captures the input.
            assign feed_vld  = in_xfer;
            assign feed_r    = A ^ B;
            assign feed_mode = mode_t'(MODE);
        end else begin : g_mid
            localparam int MID = STAGES - 1;

            logic [MID-1:0]   vld_q, vld_d;
            logic [WIDTH-1:0] r_q    [MID];
            logic [WIDTH-1:0] r_d    [MID];
            mode_t            mode_q [MID];
            mode_t            mode_d [MID];

            // Shift register of raw entries; bubbles move like any entry.
            always_comb begin
                // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
                vld_d  = vld_q;
                r_d    = r_q;
                mode_d = mode_q;
                if (!stall) begin
                    vld_d[0]  = in_xfer;
                    r_d[0]    = A ^ B;
                    mode_d[0] = mode_t'(MODE);
                    for (int i = 1; i < MID; i++) begin
                        vld_d[i]  = vld_q[i-1];
                        r_d[i]    = r_q[i-1];
                        mode_d[i] = mode_q[i-1];
                    end
                end
            end

            // Intermediate stage registers, cleared by reset.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    vld_q <= '0;
                    // NOTE: stage data is reset too (not just valid bits) so the pipe content is fully defined after reset.
                    for (int i = 0; i < MID; i++) begin
                        r_q[i]    <= '0;
                        mode_q[i] <= MODE_XOR;
                    end
                end else begin
                    // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
                    vld_q  <= vld_d;
                    r_q    <= r_d;
                    mode_q <= mode_d;
                end
            end

            assign feed_vld  = vld_q[MID-1];
            assign feed_r    = r_q[MID-1];
            assign feed_mode = mode_q[MID-1];
        end
    endgenerate

    // Output stage: apply the mode and update ACC once, as the entry loads.
    always_comb begin
        x_d         = x_q;
        parity_d    = parity_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        if (!stall) begin
            out_valid_d = feed_vld;
            if (feed_vld) begin
                // Blocking assignments here chain within the cycle: x_d feeds parity_d.
                unique case (feed_mode)
                    MODE_XOR:  x_d = feed_r;
                    MODE_XNOR: x_d = ~feed_r;
                    MODE_ACC: begin
                        acc_d = acc_q ^ feed_r;
                        x_d   = acc_q ^ feed_r;
                    end
                    MODE_CLR: begin
                        acc_d = '0;
                        x_d   = '0;
                    end
                    default:   x_d = feed_r;
                endcase
                parity_d = ^x_d;
            end
        end
    end

    // Output register and accumulator.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_q         <= '0;
            parity_q    <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            x_q         <= x_d;
            parity_q    <= parity_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
        end
    end

    assign X         = x_q;
    assign PARITY    = parity_q;
    assign OUT_VALID = out_valid_q;

`ifdef XOR_PIPE_STATS_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Transfer count wraps; stall count saturates at all-ones.
    always_comb begin
        xfer_cnt_d  = xfer_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && OUT_READY) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign XFER_CNT  = xfer_cnt_q;
    assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_xor_pipe_unit.sv
// Testbench for xor_pipe_unit (WIDTH=8, STAGES=2): table-driven streaming
// vectors plus hand-written latency, backpressure, reset and stats sequences.
module tb_xor_pipe_unit;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [WIDTH-1:0] A, B;
    logic [1:0]       MODE;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] X;
    logic             PARITY;
    logic             OUT_VALID;
    logic             OUT_READY;
`ifdef XOR_PIPE_STATS_EN
    logic [15:0]      XFER_CNT, STALL_CNT;
`endif

    xor_pipe_unit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .A         (A),
        .B         (B),
        .MODE      (MODE),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .X         (X),
        .PARITY    (PARITY),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
`ifdef XOR_PIPE_STATS_EN
        ,
        .XFER_CNT  (XFER_CNT),
        .STALL_CNT (STALL_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] mode;
        logic [7:0] x;
        logic       p;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic       p;
        int         cyc;
    } obs_t;

    vec_t vecs [14];
    obs_t obs_q [$];
    int   cyc = 0;
    bit   mon_en = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always @(posedge CLK) cyc++;

    // Record every accepted output with the cycle it was presented in.
    always @(negedge CLK) begin
        if (mon_en && RST_N && OUT_VALID && OUT_READY)
            obs_q.push_back('{x: X, p: PARITY, cyc: cyc});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_obs(input int n);
        int budget = 50;
        while (obs_q.size() < n && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        check("obs_count", obs_q.size(), n);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        A        = a;
        B        = b;
        MODE     = m;
        IN_VALID = 1'b1;
    endtask

    task automatic do_reset();
        #2 RST_N = 1'b0;
        IN_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{8'h12, 8'h34, 2'b00, 8'h26, 1'b1};
        vecs[1]  = '{8'hFF, 8'h01, 2'b00, 8'hFE, 1'b1};
        vecs[2]  = '{8'h80, 8'h00, 2'b00, 8'h80, 1'b1};
        vecs[3]  = '{8'h3C, 8'h3C, 2'b00, 8'h00, 1'b0};
        vecs[4]  = '{8'h00, 8'hFF, 2'b01, 8'h00, 1'b0};
        vecs[5]  = '{8'hFF, 8'h00, 2'b01, 8'h00, 1'b0};
        vecs[6]  = '{8'hFF, 8'hFF, 2'b01, 8'hFF, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 2'b01, 8'hFF, 1'b0};
        vecs[8]  = '{8'h5A, 8'h3C, 2'b11, 8'h00, 1'b0};
        vecs[9]  = '{8'h01, 8'h00, 2'b10, 8'h01, 1'b1};
        vecs[10] = '{8'h02, 8'h00, 2'b10, 8'h03, 1'b0};
        vecs[11] = '{8'h03, 8'h00, 2'b10, 8'h00, 1'b0};
        vecs[12] = '{8'hF0, 8'h0F, 2'b10, 8'hFF, 1'b0};
        vecs[13] = '{8'h11, 8'h10, 2'b10, 8'hFE, 1'b1};

        RST_N = 1'b1; A = '0; B = '0; MODE = 2'b00; IN_VALID = 1'b0; OUT_READY = 1'b1;

        // ---- Reset state ----
        #2 RST_N = 1'b0;
        #1;
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_x", X, 0);
        check("rst_parity", PARITY, 0);
        check("rst_in_ready", IN_READY, 1);
`ifdef XOR_PIPE_STATS_EN
        check("rst_xfer_cnt", XFER_CNT, 0);
        check("rst_stall_cnt", STALL_CNT, 0);
`endif
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // ---- Latency: A5 ^ 0F = AA visible two edges after presentation ----
        @(posedge CLK); #1;
        drive(8'hA5, 8'h0F, 2'b00);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("lat_not_early", OUT_VALID, 0);
        @(posedge CLK);
        @(negedge CLK);
        check("lat_out_valid", OUT_VALID, 1);
        check("lat_x", X, 8'hAA);
        check("lat_parity", PARITY, 0);
        repeat (3) @(posedge CLK);
        obs_q.delete();

        // ---- Table-driven back-to-back stream ----
        for (int i = 0; i < 14; i++) begin
            @(posedge CLK); #1;
            drive(vecs[i].a, vecs[i].b, vecs[i].mode);
            @(negedge CLK);
            check($sformatf("stream_in_ready[%0d]", i), IN_READY, 1);
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        wait_obs(14);
        for (int i = 0; i < 14 && i < obs_q.size(); i++) begin
            check($sformatf("stream_x[%0d]", i), obs_q[i].x, vecs[i].x);
            check($sformatf("stream_p[%0d]", i), obs_q[i].p, vecs[i].p);
            if (i > 0)
                check($sformatf("stream_gap[%0d]", i), obs_q[i].cyc - obs_q[i-1].cyc, 1);
        end
        obs_q.delete();

        // ---- Backpressure: ACC is FE here ----
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        drive(8'h01, 8'h00, 2'b10);          // ACC -> FF
        @(posedge CLK); #1;
        drive(8'h02, 8'h00, 2'b10);          // ACC -> FD
        @(posedge CLK); #1;
        drive(8'h0F, 8'hF0, 2'b00);          // XOR -> FF
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check($sformatf("bp_in_ready[%0d]", i), IN_READY, 0);
            check($sformatf("bp_out_valid[%0d]", i), OUT_VALID, 1);
            check($sformatf("bp_x_stable[%0d]", i), X, 8'hFF);
            check($sformatf("bp_p_stable[%0d]", i), PARITY, 0);
            @(posedge CLK);
        end
        #1 OUT_READY = 1'b1;
        @(negedge CLK);
        check("bp_release_in_ready", IN_READY, 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        wait_obs(3);
        if (obs_q.size() == 3) begin
            check("bp_x0", obs_q[0].x, 8'hFF);
            check("bp_x1", obs_q[1].x, 8'hFD);
            check("bp_p1", obs_q[1].p, 1);
            check("bp_x2", obs_q[2].x, 8'hFF);
            check("bp_gap1", obs_q[1].cyc - obs_q[0].cyc, 1);
            check("bp_gap2", obs_q[2].cyc - obs_q[1].cyc, 1);
        end
        obs_q.delete();

        // ---- Reset mid-stream with two entries in flight ----
        @(posedge CLK); #1;
        drive(8'h01, 8'h02, 2'b00);
        @(posedge CLK); #1;
        drive(8'h04, 8'h08, 2'b10);
        @(posedge CLK); #2;
        check("mid_pre_out_valid", OUT_VALID, 1);
        #1;
        IN_VALID = 1'b0;
        RST_N    = 1'b0;
        #1;
        check("mid_out_valid", OUT_VALID, 0);
        check("mid_x", X, 0);
        check("mid_parity", PARITY, 0);
        @(negedge CLK); #2;
        RST_N = 1'b1;
        obs_q.delete();
        for (int i = 0; i < STAGES + 2; i++) begin
            @(negedge CLK);
            check($sformatf("mid_quiet[%0d]", i), OUT_VALID, 0);
        end
        check("mid_no_obs", obs_q.size(), 0);
        // Accumulator must restart from zero.
        @(posedge CLK); #1;
        drive(8'h05, 8'h00, 2'b10);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        wait_obs(1);
        if (obs_q.size() == 1) begin
            check("mid_acc_x", obs_q[0].x, 8'h05);
            check("mid_acc_p", obs_q[0].p, 0);
        end
        obs_q.delete();

`ifdef XOR_PIPE_STATS_EN
        // ---- Statistics: 4 transfers, 3 stall cycles, then wrap ----
        do_reset();
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        drive(8'h11, 8'h22, 2'b00);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK);
        repeat (3) @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
        drive(8'h33, 8'h44, 2'b00);
        repeat (3) @(posedge CLK);
        #1 IN_VALID = 1'b0;
        repeat (STAGES + 2) @(posedge CLK);
        @(negedge CLK);
        check("stats_xfer_cnt", XFER_CNT, 16'd4);
        check("stats_stall_cnt", STALL_CNT, 16'd3);
        mon_en = 1'b0;
        @(posedge CLK); #1;
        drive(8'h55, 8'hAA, 2'b00);
        repeat (65531) @(posedge CLK);
        #1 IN_VALID = 1'b0;
        repeat (STAGES + 2) @(posedge CLK);
        @(negedge CLK);
        check("stats_xfer_full", XFER_CNT, 16'hFFFF);
        @(posedge CLK); #1;
        drive(8'h01, 8'h00, 2'b00);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (STAGES + 2) @(posedge CLK);
        @(negedge CLK);
        check("stats_xfer_wrap", XFER_CNT, 16'h0000);
        check("stats_stall_hold", STALL_CNT, 16'd3);
        mon_en = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
